// File: rtl/alu_mdu_controller_if.sv
// Decode-to-MDU bus: operand/valid/flush toward the sequencer, stall and
// writeback result back toward the core.
interface alu_mdu_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            flush_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  modport master (
    output valid_i, flush_i, rs1_i, rs2_i,
    input  stall_o, result_o, result_valid_o
  );

  modport slave (
    input  valid_i, flush_i, rs1_i, rs2_i,
    output stall_o, result_o, result_valid_o
  );
endinterface

// File: rtl/alu_mdu_controller.sv
// RV32 ALU operation decode plus iterative RV32M multiply/divide sequencer.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier (IDLE -> FIX -> DONE).
module alu_mdu_controller #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           ALUOp,
  input  logic [6:0]           Funct7,
  input  logic [2:0]           Funct3,
  output logic [3:0]           Operation,
  output logic                 mdu_sel_o,
  alu_mdu_controller_if.slave  mdu
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1111;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic              neg_a_q;
  logic              neg_prod_q;
  logic [XLEN-1:0]   a_mag_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;

  assign mdu_sel_o = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);

  always_comb begin
    Operation = OP_ADD;
    if (!mdu_sel_o) begin
      case (ALUOp)
        2'b00: Operation = OP_ADD;
        2'b01: Operation = OP_SUB;
        default: begin
          case (Funct3)
            3'b000:  Operation = (ALUOp == 2'b10 && Funct7[5]) ? OP_SUB : OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b011:  Operation = OP_SLTU;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = Funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  Operation = OP_OR;
            default: Operation = OP_AND;
          endcase
        end
      endcase
    end
  end

  logic            is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic            div_zero, div_ovf, accept;

  always_comb begin
    is_div      = Funct3[2];
    a_signed    = is_div ? !Funct3[0] : (Funct3 != 3'b011);
    b_signed    = is_div ? !Funct3[0] : !Funct3[1];
    neg_a       = a_signed && mdu.rs1_i[XLEN-1];
    neg_b       = b_signed && mdu.rs2_i[XLEN-1];
    a_mag       = neg_a ? -mdu.rs1_i : mdu.rs1_i;
    b_mag       = neg_b ? -mdu.rs2_i : mdu.rs2_i;
    div_zero    = is_div && (mdu.rs2_i == '0);
    div_ovf     = is_div && !Funct3[0] && (mdu.rs2_i == '1) &&
                  (mdu.rs1_i == {1'b1, {(XLEN-1){1'b0}}});
    // Funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) special_res = Funct3[1] ? mdu.rs1_i : '1;
    else          special_res = Funct3[1] ? '0 : mdu.rs1_i;
    accept      = (state == S_IDLE) && mdu.valid_i && mdu_sel_o && !mdu.flush_i;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  always_comb begin
    fa    = {{XLEN{a_signed && mdu.rs1_i[XLEN-1]}}, mdu.rs1_i};
    fb    = {{XLEN{b_signed && mdu.rs2_i[XLEN-1]}}, mdu.rs2_i};
    fprod = fa * fb;
  end
`endif

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quot, remv, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? a_mag_q : '0)};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    prod_fix  = neg_prod_q ? -acc : acc;
    quot      = neg_prod_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remv      = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (f3_q[2])             fix_res = f3_q[1] ? remv : quot;
    else if (f3_q[1:0] == 0) fix_res = prod_fix[XLEN-1:0];
    else                     fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_prod_q <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      acc        <= '0;
      result_q   <= '0;
    end else if (mdu.flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3_q       <= Funct3;
            neg_a_q    <= neg_a;
            neg_prod_q <= neg_a ^ neg_b;
            a_mag_q    <= a_mag;
            b_mag_q    <= b_mag;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              state    <= S_DONE;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!is_div) begin
              // product is already signed-correct; skip negation in FIX
              acc        <= fprod;
              neg_prod_q <= 1'b0;
              state      <= S_FIX;
            end
`endif
            else begin
              acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              cnt   <= CNT_W'(XLEN - 1);
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc <= f3_q[2] ? div_next : mul_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          result_q <= fix_res;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mdu.stall_o        = accept || (state != S_IDLE);
  assign mdu.result_valid_o = (state == S_DONE);
  assign mdu.result_o       = result_q;

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed bench: decode table plus scoreboarded M-op results and latencies.
module tb_alu_mdu_controller;
  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [6:0] Funct7 = 7'd0;
  logic [2:0] Funct3 = 3'd0;
  logic [3:0] Operation;
  logic       mdu_sel_o;

  alu_mdu_controller_if #(.XLEN(XLEN)) mif ();

  alu_mdu_controller #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .Operation (Operation),
    .mdu_sel_o (mdu_sel_o),
    .mdu       (mif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mif.result_valid_o) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pulse got=%h at cycle %0d want=no pulse", mif.result_o, cyc);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_result"}, mif.result_o, e.res);
          check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  // Call just after a negedge; returns just after the negedge where stall_o drops.
  task automatic mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input int lat, input string nm, input bit junk);
    int scount;
    bit done;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
    mif.rs1_i = a; mif.rs2_i = b; mif.valid_i = 1'b1;
    #1;
    check({nm, "_stall_accept"}, 32'(mif.stall_o), 32'd1);
    sbq.push_back('{want, cyc + lat, nm});
    scount = 1;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!mif.stall_o) begin
        done = 1'b1;
      end else begin
        scount++;
        if (!junk || mif.result_valid_o) mif.valid_i = 1'b0;
        if (junk && !mif.result_valid_o) begin
          mif.rs1_i = $urandom; mif.rs2_i = $urandom; Funct3 = 3'($urandom);
        end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout got=stall stuck want=release within 100 cycles", nm);
    end
    mif.valid_i = 1'b0;
    Funct3 = f3;
    check({nm, "_stall_cycles"}, 32'(scount), 32'(lat + 1));
  endtask

  typedef struct {
    logic [1:0] aop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic       sel;
  } dec_t;

  dec_t dtab[16] = '{
    '{2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0},
    '{2'b11, 7'b0100000, 3'b000, 4'b0010, 1'b0},
    '{2'b10, 7'b0100000, 3'b101, 4'b1010, 1'b0},
    '{2'b10, 7'b0000000, 3'b101, 4'b1000, 1'b0},
    '{2'b11, 7'b0100000, 3'b101, 4'b1010, 1'b0},
    '{2'b11, 7'b0000000, 3'b101, 4'b1000, 1'b0},
    '{2'b00, 7'b0100000, 3'b111, 4'b0010, 1'b0},
    '{2'b01, 7'b0000000, 3'b100, 4'b0110, 1'b0},
    '{2'b10, 7'b0000000, 3'b001, 4'b0011, 1'b0},
    '{2'b10, 7'b0000000, 3'b010, 4'b0111, 1'b0},
    '{2'b10, 7'b0000000, 3'b011, 4'b1111, 1'b0},
    '{2'b10, 7'b0000000, 3'b100, 4'b1100, 1'b0},
    '{2'b10, 7'b0000000, 3'b110, 4'b0001, 1'b0},
    '{2'b10, 7'b0000000, 3'b111, 4'b0000, 1'b0},
    '{2'b10, 7'b0000001, 3'b111, 4'b0010, 1'b1},
    '{2'b11, 7'b0000001, 3'b000, 4'b0010, 1'b0}
  };

  initial begin
    mif.valid_i = 1'b0; mif.flush_i = 1'b0; mif.rs1_i = '0; mif.rs2_i = '0;
    #1;
    check("reset_stall", 32'(mif.stall_o), 32'd0);
    check("reset_rvalid", 32'(mif.result_valid_o), 32'd0);
    check("reset_result", mif.result_o, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dtab[i]) begin
      @(negedge clk);
      ALUOp = dtab[i].aop; Funct7 = dtab[i].f7; Funct3 = dtab[i].f3;
      #1;
      check($sformatf("decode%0d_op", i), 32'(Operation), 32'(dtab[i].op));
      check($sformatf("decode%0d_sel", i), 32'(mdu_sel_o), 32'(dtab[i].sel));
    end

    @(negedge clk);
    mop(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "mul_7x-3", 1'b0);
    mop(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu_max", 1'b0);
    mop(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "mulh_m1m1", 1'b0);
    mop(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "mulhsu_m1", 1'b0);
    mop(3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT, "mul_shift", 1'b0);
    mop(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "div_-7_2", 1'b0);
    mop(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "rem_-7_2", 1'b0);
    mop(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, "div_7_-2", 1'b0);
    mop(3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT, "rem_7_-2", 1'b0);
    mop(3'b101, 32'd100,      32'd7,        32'h0000000E, DIV_LAT, "divu_100_7", 1'b0);
    mop(3'b111, 32'd100,      32'd7,        32'h00000002, DIV_LAT, "remu_100_7", 1'b0);
    mop(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,       "divu_by0", 1'b0);
    mop(3'b110, 32'd5,        32'd0,        32'h00000005, 1,       "rem_by0", 1'b0);
    mop(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       "div_ovf", 1'b0);
    mop(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,       "rem_ovf", 1'b0);
    mop(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "div_junk_inputs", 1'b1);

    // flush during RUN, then immediate new accept
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
    mif.rs1_i = 32'd1000; mif.rs2_i = 32'd3; mif.valid_i = 1'b1;
    @(negedge clk); mif.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    mif.flush_i = 1'b1;
    @(negedge clk); mif.flush_i = 1'b0;
    #1;
    check("flush_stall_low", 32'(mif.stall_o), 32'd0);
    mop(3'b101, 32'd1000, 32'd3, 32'd333, DIV_LAT, "after_flush", 1'b0);

    // flush in the accept cycle cancels it
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
    mif.rs1_i = 32'd3; mif.rs2_i = 32'd3; mif.valid_i = 1'b1; mif.flush_i = 1'b1;
    #1;
    check("flush_accept_stall", 32'(mif.stall_o), 32'd0);
    @(negedge clk); mif.valid_i = 1'b0; mif.flush_i = 1'b0;
    #1;
    check("flush_accept_idle", 32'(mif.stall_o), 32'd0);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-RUN
    Funct3 = 3'b000; mif.rs1_i = 32'd9; mif.rs2_i = 32'd9; mif.valid_i = 1'b1;
    @(negedge clk); mif.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #2; rst_n = 1'b0; ALUOp = 2'b01;
    #1;
    check("rst_mid_stall", 32'(mif.stall_o), 32'd0);
    check("rst_mid_rvalid", 32'(mif.result_valid_o), 32'd0);
    check("rst_mid_result", mif.result_o, 32'd0);
    check("rst_mid_operation", 32'(Operation), 32'b0110);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_mdu_controller.md
Name: alu_mdu_controller

Overview:
- Next-generation ALU controller for the single-cycle RV32 core.
- Keeps the combinational ALUOp/Funct7/Funct3 to 4-bit Operation decode for base integer ops, extended with shifts and SLTU.
- Adds an XLEN-parametrised, iterative multiply/divide sequencer for the RV32M instructions.
- Raises a stall to the core while an M-op is in flight, then returns a one-cycle result pulse for writeback.

Parameters:
- XLEN, 32: operand/result width; iteration count of the multi-cycle engine.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ALUOp  in  2  main-decoder class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- Funct7  in  7  instruction funct7
- Funct3  in  3  instruction funct3
- valid_i  in  1  instruction in decode is valid this cycle
- flush_i  in  1  abort any in-flight M-op
- rs1_i  in  XLEN  operand A
- rs2_i  in  XLEN  operand B
- Operation  out  4  base ALU operation code
- mdu_sel_o  out  1  current instruction is an M-op (combinational)
- stall_o  out  1  hold PC and pipeline
- result_o  out  XLEN  M-op result
- result_valid_o  out  1  one-cycle pulse, result_o valid

Behaviour:
- Operation decode, combinational:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1100, SLT 0111, SLTU 1111, SLL 0011, SRL 1000, SRA 1010.
  - ALUOp 00 -> ADD; ALUOp 01 -> SUB.
  - ALUOp 10 uses Funct3 and Funct7[5]: SUB/SRA when Funct7[5]=1.
  - ALUOp 11 ignores Funct7[5] except for Funct3=101, where it selects SRA.
  - When mdu_sel_o=1, Operation=0010.
- mdu_sel_o = (ALUOp==10) && (Funct7==0000001).
- Accept: valid_i && mdu_sel_o while state IDLE.
  - Latches Funct3, rs1_i, rs2_i, operand signs and operand magnitudes.
  - stall_o goes high combinationally in the accept cycle and stays high until the DONE cycle inclusive.
- FSM states and transitions:
  - IDLE -> RUN on accept.
  - IDLE -> DONE on accept of a special-case divide.
  - RUN performs one shift-add (mul) or restoring-subtract (div) step per cycle; counter runs from XLEN-1 down to 0, then RUN -> FIX.
  - FIX applies sign correction, registers result_o, then FIX -> DONE.
  - DONE drives result_valid_o=1 for exactly one cycle, then DONE -> IDLE.
  - Normal latency: accept to result_valid_o = XLEN+2 cycles (34 at default).
- Multiply:
  - 2*XLEN-bit product of the magnitudes.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Signed variants negate the full 2*XLEN-bit product when the operand signs differ.
- Divide:
  - DIV/REM: quotient negated if signs differ; remainder takes the dividend's sign.
  - DIVU/REMU: no sign correction.
- Special-case divides, 1-cycle path IDLE -> DONE (accept to pulse = 1 cycle):
  - Divisor zero: quotient all-ones, remainder = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1, remainder = 0.
- Boundary conditions:
  - valid_i or new operands while not IDLE: ignored; latched values hold.
  - flush_i in any state: next state IDLE, stall_o low next cycle, no result_valid_o pulse. flush_i in the accept cycle cancels that accept.
  - Back-to-back M-ops: a second accept is possible the cycle after DONE.
  - Reset, including mid-operation: state IDLE; stall_o=0, result_valid_o=0, result_o=0, counter=0. Operation and mdu_sel_o follow their inputs.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - Multiplies use a single-cycle XLEN x XLEN signed/unsigned product computed in the accept cycle.
  - Path is IDLE -> FIX -> DONE; latency 2 cycles.
  - Divides unchanged.
- Undefined: iterative multiply as specified above; no multiplier inferred.

Test Plan:
- Base decode:
  - ALUOp=10, Funct7=0100000, Funct3=000 -> Operation=0110.
  - ALUOp=11, Funct7=0100000, Funct3=000 -> Operation=0010.
  - ALUOp=10, Funct3=101, Funct7[5]=1 -> Operation=1010.
- MUL: rs1=7, rs2=-3 (MUL, Funct3=000) -> stall_o high 35 cycles; result_valid_o pulse at cycle 34; result_o=0xFFFFFFEB. With MDU_FAST_MUL_EN: pulse at cycle 2.
- MULHU: rs1=rs2=0xFFFFFFFF -> result_o=0xFFFFFFFE. MULH with the same operands -> 0x00000000.
- DIV/REM: rs1=-7, rs2=2 -> DIV result_o=0xFFFFFFFD (-3); REM result_o=0xFFFFFFFF (-1).
- Special cases:
  - DIVU by 0 with rs1=5 -> 0xFFFFFFFF one cycle after accept.
  - REM by 0 -> 5.
  - DIV 0x80000000 / -1 -> 0x80000000, 1-cycle latency.
- flush_i asserted at RUN cycle 10 -> stall_o low next cycle, no pulse; a new M-op is accepted immediately after. rst_n asserted mid-RUN -> all outputs 0 asynchronously.
